mem_port_arbiter: RTL

Arbiter and sequencer for a single-ported, fixed-wait-state unified memory shared by the fetch stage and the memory stage of the five-stage RISC-V pipeline. It holds each access for a programmable number of cycles and returns read data through a one-cycle ready pulse. While an access is outstanding, the requester's `ready` stays low. The pipeline uses `~if_ready` to stall the PC and IF/ID register and `~dm_ready` to stall the whole pipe.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter and wait-state sequencer for the shared unified memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              grant_dm;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pick_dm;

`ifdef MEM_ARB_RR_EN
    logic last_dm;

    // On contention the requester not served last wins.
    always_comb begin
        pick_dm = dm_req;
        if (dm_req && if_req) begin
            pick_dm = ~last_dm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dm <= 1'b0;
        end else if (state == S_IDLE && (if_req || dm_req)) begin
            last_dm <= pick_dm;
        end
    end
`else
    assign pick_dm = dm_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            grant_dm <= 1'b1;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (if_req || dm_req) begin
                        grant_dm <= pick_dm;
                        addr_q   <= pick_dm ? dm_addr : if_addr;
                        we_q     <= pick_dm & dm_we;
                        wdata_q  <= pick_dm ? dm_wdata : '0;
                        cnt      <= 4'd0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_RESP;
                        if (!we_q) begin
                            if (grant_dm) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state == S_BUSY);
    assign mem_we    = mem_en & we_q & grant_dm;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ready  = (state == S_RESP) & ~grant_dm;
    assign dm_ready  = (state == S_RESP) & grant_dm;

endmodule
